irq_nest_ctrl: RTL and testbench
================================

# irq_nest_ctrl

Priority interrupt controller for the pipelined CPU. It synchronizes three external interrupt lines, latches them as pending, and arbitrates by fixed priority against a global enable and a per-source mask. It drives a req/ack handshake to the pipeline front end with the handler entry address, and keeps a 3-deep return stack of {PC, level} so that a higher-priority source can preempt a running handler and eret unwinds one level at a time.

## Interface
- ENTRY1, 32'h0cdc, handler entry address for source 0 (level 1, lowest priority)
- ENTRY2, 32'h0d0d, handler entry address for source 1 (level 2)
- ENTRY3, 32'h0d3e, handler entry address for source 2 (level 3, highest priority)
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- irq_in  in  3  asynchronous interrupt lines; a rising edge requests service
- ie_we, ie_wdata  in  1,1  global-enable write strobe and data
- mask_we, mask_wdata  in  1,3  mask write strobe and data; mask bit = 1 blocks that source
- ret_pc  in  32  resume PC supplied by the pipeline; sampled on the ack cycle
- irq_ack  in  1  pipeline has flushed and is redirecting to irq_entry
- eret  in  1  one-cycle pulse; the handler returns
- irq_req  out  1  interrupt request to the pipeline
- irq_entry  out  32  entry address of the granted source; valid while irq_req = 1
- epc_out  out  32  PC field of the top stack entry; 0 when the stack is empty
- cur_level  out  2  level currently in service; 0 = none
- pending  out  3  latched pending sources
- in_service  out  3  one bit per source currently on the stack
- nest_depth  out  2  number of stack entries (0-3)
- err  out  1  sticky protocol-error flag

## Operation
- Each irq_in bit passes through a 2-flop synchronizer plus a third flop for edge detection. A detected rising edge sets the matching pending bit.
  - Set wins over a clear in the same cycle.
  - A new edge on a source that is already pending merges with it; only one service results.
- Eligibility: pending[i] & ~mask[i] & ie & ((i+1) > cur_level). Source 2 has the highest priority.
- FSM state IDLE:
  - irq_req = 0.
  - If any source is eligible, latch the highest eligible index as grant and move to REQ.
- FSM state REQ:
  - irq_req = 1. irq_entry = ENTRY(grant+1).
  - grant is frozen: no re-arbitration, and mask/ie writes do not withdraw the request.
  - On irq_ack:
    - push {cur_level, ret_pc};
    - cur_level <= grant+1;
    - clear pending[grant];
    - set in_service[grant];
    - return to IDLE.
- eret accepted (nest_depth > 0, no ack in the same cycle):
  - pop the stack;
  - cur_level <= the popped level;
  - clear the in_service bit of the level being left.
  - During the eret cycle, epc_out shows the entry being popped; the pipeline uses it as the return target.
- Errors (err is set and held until rst):
  - eret with nest_depth = 0: ignored.
  - eret in the same cycle as irq_ack: ack is processed, eret is dropped.
  - irq_ack outside REQ: ignored, no err.
- Stack overflow is impossible: levels strictly increase on each push, so the stack never exceeds 3 entries.
- A ie/mask write takes effect from the next cycle's arbitration.

## Timing
- Reset values:
  - irq_req = 0, irq_entry = 0, epc_out = 0;
  - cur_level = 0, pending = 0, in_service = 0, nest_depth = 0;
  - err = 0, ie = 0, mask = 3'b000;
  - FSM in IDLE, synchronizers cleared.
- irq_in must stay high across at least one rising edge. Counting from the first edge E0 that samples it high:
  - pending is set after E2;
  - irq_req rises after E3 (if eligible).
- irq_req stays high until the edge that samples irq_ack. It is low in the following cycle.
- Back-to-back service: after an ack, a still-eligible higher source raises irq_req again 1 cycle later (IDLE for one cycle).
- eret takes effect at its edge. A lower source blocked by the old level can request starting 1 cycle after that edge.
- rst asserted mid-handshake or mid-nest clears everything immediately, including the stack.

## Test plan
- **Single source.** ie=1, pulse irq_in[0], ack with ret_pc=32'h100.
  - irq_req after E3, irq_entry=32'h0cdc.
  - After ack: cur_level=1, nest_depth=1, epc_out=32'h100.
  - After eret: cur_level=0, epc_out=0.
- **Simultaneous sources.** Pulse irq_in[0] and irq_in[2] together.
  - Grant 2 first (entry 32'h0d3e).
  - After its ack, source 0 stays pending and does not request until eret returns cur_level to 0.
- **Nesting.** In service of source 0 (ret_pc=32'h40), pulse irq_in[1] and ack with ret_pc=32'h0ce0.
  - nest_depth=2, cur_level=2.
  - First eret: epc_out=32'h0ce0, cur_level=1.
  - Second eret: epc_out=32'h40, cur_level=0.
- **Mask and global enable.**
  - With mask=3'b010, a pulse on irq_in[1] gives pending[1]=1 and no irq_req.
  - Writing mask=0 gives irq_req 1 cycle later.
  - With ie=0, no request is raised for any source.
- **Errors.**
  - eret with nest_depth=0: err=1, no other state change.
  - eret in the same cycle as ack: ack is applied, err=1.
- **Reset mid-operation.** Assert rst while in REQ with nest_depth=2: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/irq_nest_ctrl.sv
// Three-source nested interrupt controller: sync/edge detect, fixed-priority
// arbitration, req/ack handshake and a 3-deep {PC, level} return stack.
module irq_nest_ctrl #(
  parameter logic [31:0] ENTRY1 = 32'h0cdc,
  parameter logic [31:0] ENTRY2 = 32'h0d0d,
  parameter logic [31:0] ENTRY3 = 32'h0d3e
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  irq_in,
  input  logic        ie_we,
  input  logic        ie_wdata,
  input  logic        mask_we,
  input  logic [2:0]  mask_wdata,
  input  logic [31:0] ret_pc,
  input  logic        irq_ack,
  input  logic        eret,
  output logic        irq_req,
  output logic [31:0] irq_entry,
  output logic [31:0] epc_out,
  output logic [1:0]  cur_level,
  output logic [2:0]  pending,
  output logic [2:0]  in_service,
  output logic [1:0]  nest_depth,
  output logic        err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [0:0]  state;
  logic [1:0]  grant;
  logic [1:0]  pick;
  logic        ie;
  logic [2:0]  mask;
  logic [2:0]  s1, s2, s3;
  logic [2:0]  rise;
  logic [2:0]  lvl_ok;
  logic [2:0]  elig;
  logic        ack_ok;
  logic        eret_ok;
  logic        eret_bad;
  logic [31:0] pc_stk [3];
  logic [1:0]  lv_stk [3];
  logic [31:0] top_pc;
  logic [1:0]  top_lv;
  logic [2:0]  ack_bit;
  logic [2:0]  ret_bit;

  assign rise     = s2 & ~s3;
  assign lvl_ok   = {cur_level < 2'd3, cur_level < 2'd2, cur_level == 2'd0};
  assign elig     = pending & ~mask & {3{ie}} & lvl_ok;
  assign ack_ok   = (state == REQ) & irq_ack;
  assign eret_ok  = eret & (nest_depth != 2'd0) & ~ack_ok;
  assign eret_bad = eret & ((nest_depth == 2'd0) | ack_ok);
  assign irq_req  = (state == REQ);
  assign epc_out  = top_pc;
  assign ack_bit  = ack_ok ? (3'b001 << grant) : 3'b000;
  assign ret_bit  = eret_ok ? (3'b001 << (cur_level - 2'd1)) : 3'b000;

  always_comb begin
    pick = 2'd0;
    priority case (1'b1)
      elig[2]: pick = 2'd2;
      elig[1]: pick = 2'd1;
      default: pick = 2'd0;
    endcase
  end

  always_comb begin
    irq_entry = 32'h0;
    if (state == REQ) begin
      unique case (grant)
        2'd2:    irq_entry = ENTRY3;
        2'd1:    irq_entry = ENTRY2;
        default: irq_entry = ENTRY1;
      endcase
    end
  end

  // Top of stack sits one below the depth counter.
  always_comb begin
    top_pc = 32'h0;
    top_lv = 2'd0;
    unique case (nest_depth)
      2'd1: begin top_pc = pc_stk[0]; top_lv = lv_stk[0]; end
      2'd2: begin top_pc = pc_stk[1]; top_lv = lv_stk[1]; end
      2'd3: begin top_pc = pc_stk[2]; top_lv = lv_stk[2]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 3'b0;
      s2 <= 3'b0;
      s3 <= 3'b0;
      ie <= 1'b0;
      mask <= 3'b0;
      pending <= 3'b0;
      err <= 1'b0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
      if (ie_we) ie <= ie_wdata;
      if (mask_we) mask <= mask_wdata;
      pending <= (pending & ~ack_bit) | rise;
      if (eret_bad) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 2'd0;
    end else begin
      unique case (state)
        IDLE: if (|elig) begin
          state <= REQ;
          grant <= pick;
        end
        REQ: if (irq_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_level <= 2'd0;
      nest_depth <= 2'd0;
      in_service <= 3'b0;
      for (int i = 0; i < 3; i++) begin
        pc_stk[i] <= 32'h0;
        lv_stk[i] <= 2'd0;
      end
    end else begin
      in_service <= (in_service | ack_bit) & ~ret_bit;
      if (ack_ok) begin
        cur_level <= grant + 2'd1;
        nest_depth <= nest_depth + 2'd1;
        for (int i = 0; i < 3; i++) begin
          if (nest_depth == 2'(i)) begin
            pc_stk[i] <= ret_pc;
            lv_stk[i] <= cur_level;
          end
        end
      end else if (eret_ok) begin
        cur_level <= top_lv;
        nest_depth <= nest_depth - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Bench for irq_nest_ctrl: directed scenarios then random traffic, all
// outputs compared every cycle against a queue-based reference model.
module tb_irq_nest_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  irq_in = 3'b0;
  logic        ie_we = 1'b0;
  logic        ie_wdata = 1'b0;
  logic        mask_we = 1'b0;
  logic [2:0]  mask_wdata = 3'b0;
  logic [31:0] ret_pc = 32'h0;
  logic        irq_ack = 1'b0;
  logic        eret = 1'b0;
  logic        irq_req;
  logic [31:0] irq_entry;
  logic [31:0] epc_out;
  logic [1:0]  cur_level;
  logic [2:0]  pending;
  logic [2:0]  in_service;
  logic [1:0]  nest_depth;
  logic        err;

  int checks = 0;
  int failures = 0;

  irq_nest_ctrl dut (
    .clk(clk), .rst(rst), .irq_in(irq_in),
    .ie_we(ie_we), .ie_wdata(ie_wdata),
    .mask_we(mask_we), .mask_wdata(mask_wdata),
    .ret_pc(ret_pc), .irq_ack(irq_ack), .eret(eret),
    .irq_req(irq_req), .irq_entry(irq_entry), .epc_out(epc_out),
    .cur_level(cur_level), .pending(pending), .in_service(in_service),
    .nest_depth(nest_depth), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          lvl;
  } frame_t;

  logic [31:0] entry_tab [3] = '{32'h0cdc, 32'h0d0d, 32'h0d3e};

  frame_t   stk[$];
  bit [2:0] hist[$];
  bit [2:0] m_pend, m_mask, m_isv;
  bit       m_ie, m_req, m_err;
  int       m_grant, m_lvl;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    hist = '{3'b0, 3'b0, 3'b0};
    m_pend = 0; m_mask = 0; m_isv = 0;
    m_ie = 0; m_req = 0; m_err = 0;
    m_grant = 0; m_lvl = 0;
  endtask

  // hist[0] = sample at last edge, hist[1] two edges ago, hist[2] three.
  task automatic model_edge();
    bit       ack;
    bit [2:0] edg, elig, npend;
    frame_t   fr;
    ack = m_req && irq_ack;
    edg = hist[1] & ~hist[2];
    elig = 0;
    for (int i = 0; i < 3; i++)
      if (m_pend[i] && !m_mask[i] && m_ie && (i + 1 > m_lvl)) elig[i] = 1;
    npend = m_pend;
    if (ack) npend[m_grant] = 0;
    npend |= edg;
    if (ack) begin
      stk.push_back('{ret_pc, m_lvl});
      m_isv[m_grant] = 1;
      m_lvl = m_grant + 1;
      m_req = 0;
    end else if (!m_req && elig != 0) begin
      m_req = 1;
      m_grant = elig[2] ? 2 : (elig[1] ? 1 : 0);
    end
    if (eret) begin
      if (ack || stk.size() == 0) m_err = 1;
      else begin
        fr = stk.pop_back();
        m_isv[m_lvl - 1] = 0;
        m_lvl = fr.lvl;
      end
    end
    if (ie_we) m_ie = ie_wdata;
    if (mask_we) m_mask = mask_wdata;
    m_pend = npend;
    hist.push_front(3'(irq_in));
    void'(hist.pop_back());
  endtask

  task automatic compare();
    chk("irq_req", 32'(irq_req), 32'(m_req));
    chk("irq_entry", irq_entry, m_req ? entry_tab[m_grant] : 32'h0);
    chk("epc_out", epc_out, stk.size() == 0 ? 32'h0 : stk[$].pc);
    chk("cur_level", 32'(cur_level), 32'(m_lvl));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("in_service", 32'(in_service), 32'(m_isv));
    chk("nest_depth", 32'(nest_depth), 32'(stk.size()));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] b, input int n);
    irq_in = b;
    step();
    irq_in = 3'b0;
    repeat (n) step();
  endtask

  task automatic ack(input logic [31:0] pc);
    ret_pc = pc;
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  task automatic wr_ie(input logic v);
    ie_we = 1'b1;
    ie_wdata = v;
    step();
    ie_we = 1'b0;
  endtask

  task automatic wr_mask(input logic [2:0] v);
    mask_we = 1'b1;
    mask_wdata = v;
    step();
    mask_we = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("rst_req", 32'(irq_req), 32'h0);
    wr_ie(1'b1);

    // single source
    pulse(3'b001, 2);
    chk("pend_after_e2", 32'(pending[0]), 32'h1);
    chk("no_req_before_e3", 32'(irq_req), 32'h0);
    step();
    chk("req_after_e3", 32'(irq_req), 32'h1);
    chk("entry_src0", irq_entry, 32'h0cdc);
    ack(32'h100);
    chk("single_lvl", 32'(cur_level), 32'h1);
    chk("single_depth", 32'(nest_depth), 32'h1);
    chk("single_epc", epc_out, 32'h100);
    step();
    do_eret();
    chk("single_ret_lvl", 32'(cur_level), 32'h0);
    chk("single_ret_epc", epc_out, 32'h0);

    // simultaneous sources
    pulse(3'b101, 3);
    chk("simul_entry2", irq_entry, 32'h0d3e);
    ack(32'h200);
    repeat (4) step();
    chk("simul_blocked", 32'(irq_req), 32'h0);
    chk("simul_pend0", 32'(pending[0]), 32'h1);
    do_eret();
    step();
    chk("simul_src0_req", irq_entry, 32'h0cdc);
    ack(32'h300);
    do_eret();

    // nesting
    pulse(3'b001, 3);
    ack(32'h40);
    pulse(3'b010, 3);
    chk("nest_entry1", irq_entry, 32'h0d0d);
    ack(32'h0ce0);
    chk("nest_depth2", 32'(nest_depth), 32'h2);
    chk("nest_lvl2", 32'(cur_level), 32'h2);
    chk("nest_epc_top", epc_out, 32'h0ce0);
    do_eret();
    chk("nest_ret1_lvl", 32'(cur_level), 32'h1);
    chk("nest_ret1_epc", epc_out, 32'h40);
    do_eret();
    chk("nest_ret2_lvl", 32'(cur_level), 32'h0);
    chk("nest_ret2_epc", epc_out, 32'h0);

    // mask and global enable
    wr_mask(3'b010);
    pulse(3'b010, 5);
    chk("mask_pend1", 32'(pending[1]), 32'h1);
    chk("mask_no_req", 32'(irq_req), 32'h0);
    wr_mask(3'b000);
    chk("unmask_not_yet", 32'(irq_req), 32'h0);
    step();
    chk("unmask_req", 32'(irq_req), 32'h1);
    ack(32'h500);
    do_eret();
    wr_ie(1'b0);
    pulse(3'b111, 5);
    chk("ie0_no_req", 32'(irq_req), 32'h0);
    chk("ie0_pend", 32'(pending), 32'h7);
    wr_ie(1'b1);
    step();
    chk("ie1_req_top", irq_entry, 32'h0d3e);

    // errors
    do_reset();
    wr_ie(1'b1);
    do_eret();
    chk("eret_empty_err", 32'(err), 32'h1);
    chk("eret_empty_depth", 32'(nest_depth), 32'h0);
    do_reset();
    wr_ie(1'b1);
    pulse(3'b001, 3);
    ret_pc = 32'h77;
    irq_ack = 1'b1;
    eret = 1'b1;
    step();
    irq_ack = 1'b0;
    eret = 1'b0;
    chk("ack_eret_depth", 32'(nest_depth), 32'h1);
    chk("ack_eret_lvl", 32'(cur_level), 32'h1);
    chk("ack_eret_err", 32'(err), 32'h1);

    // reset mid-nest
    do_reset();
    wr_ie(1'b1);
    pulse(3'b001, 3);
    ack(32'h10);
    pulse(3'b010, 3);
    ack(32'h20);
    pulse(3'b100, 3);
    chk("pre_rst_req", 32'(irq_req), 32'h1);
    chk("pre_rst_depth", 32'(nest_depth), 32'h2);
    do_reset();
    chk("post_rst_depth", 32'(nest_depth), 32'h0);
    chk("post_rst_entry", irq_entry, 32'h0);

    // random traffic
    wr_ie(1'b1);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) irq_in = 3'($urandom_range(0, 7));
      irq_ack = (m_req && $urandom_range(0, 2) == 0) ||
                ($urandom_range(0, 29) == 0);
      eret = ($urandom_range(0, 11) == 0);
      mask_we = ($urandom_range(0, 39) == 0);
      mask_wdata = 3'($urandom_range(0, 7));
      ie_we = ($urandom_range(0, 59) == 0);
      ie_wdata = ($urandom_range(0, 3) != 0);
      ret_pc = $urandom;
      step();
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        wr_ie(1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
